// File: rtl/text_term_pkg.sv
// Shared constants and FSM state type for the UART text terminal writer.
package text_term_pkg;

  localparam logic [7:0] CHR_CR     = 8'h0D;
  localparam logic [7:0] CHR_LF     = 8'h0A;
  localparam logic [7:0] CHR_BS     = 8'h08;
  localparam logic [7:0] CHR_FF     = 8'h0C;
  localparam logic [7:0] CHR_SP_MIN = 8'h20;
  localparam logic [7:0] CHR_SP_MAX = 8'h7E;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    CLR_ROW,
    CLR_ALL
  } term_state_e;

endpackage

// File: rtl/text_ram.sv
// Character store: one write port, one registered read-first read port.
module text_ram #(
  parameter int          DEPTH  = 128,
  parameter int          ADDR_W = 7,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rd_blank,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rd_data_d = rd_blank ? BLANK : mem[raddr];
  end

  // Only the output register is reset; the array content is cleared by the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= BLANK;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_text_terminal.sv
// Places received bytes into a scrolling ROWS x COLS character screen and
// serves a logical-position read port to the glyph renderer.
module uart_text_terminal
  import text_term_pkg::*;
#(
  parameter int         COLS      = 32,
  parameter int         ROWS      = 4,
  parameter bit         SCROLL_EN = 1'b1,
  parameter logic [7:0] BLANK     = 8'h20,
  localparam int        COL_W     = $clog2(COLS),
  localparam int        ROW_W     = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic [7:0]       rd_data,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int                CELLS      = ROWS * COLS;
  localparam int                ADDR_W     = $clog2(CELLS);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] LAST_RCELL = ADDR_W'(COLS - 1);

  term_state_e       state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  top_q, top_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic              ovf_q, ovf_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              newline;
  logic              rd_oob;
  logic [ADDR_W-1:0] raddr;

  // Logical rows are rotated by top_row so scrolling never moves data.
  function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] lrow,
                                                input logic [ROW_W-1:0] top);
    logic [ROW_W:0] sum;
    sum = {1'b0, lrow} + {1'b0, top};
    if (sum >= (ROW_W+1)'(ROWS)) sum = sum - (ROW_W+1)'(ROWS);
    return sum[ROW_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    top_d   = top_q;
    clr_d   = clr_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = BLANK;
    newline = 1'b0;
    case (state_q)
      INIT_CLR, CLR_ALL: begin
        we    = 1'b1;
        waddr = clr_q;
        if (clr_q == LAST_CELL) begin
          clr_d   = '0;
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          top_d   = '0;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      CLR_ROW: begin
        we    = 1'b1;
        waddr = cell_addr(phys_row(LAST_ROW, top_q), COL_W'(clr_q));
        if (clr_q == LAST_RCELL) begin
          clr_d   = '0;
          state_d = IDLE;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      IDLE: begin
        if (rx_valid) begin
          if (rx_data >= CHR_SP_MIN && rx_data <= CHR_SP_MAX) begin
            we    = 1'b1;
            waddr = cell_addr(phys_row(row_q, top_q), col_q);
            wdata = rx_data;
            if (col_q != LAST_COL) begin
              col_d = col_q + 1'b1;
            end else begin
              col_d   = '0;
              newline = 1'b1;
            end
          end else begin
            case (rx_data)
              CHR_CR: col_d = '0;
              CHR_LF: newline = 1'b1;
              CHR_BS: begin
                if (col_q != '0 || row_q != '0) begin
                  if (col_q != '0) begin
                    col_d = col_q - 1'b1;
                  end else begin
                    row_d = row_q - 1'b1;
                    col_d = LAST_COL;
                  end
                  we    = 1'b1;
                  waddr = cell_addr(phys_row(row_d, top_q), col_d);
                end
              end
              CHR_FF: begin
                state_d = CLR_ALL;
                clr_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = INIT_CLR;
    endcase

    if (newline) begin
      if (row_q == LAST_ROW) begin
        if (SCROLL_EN) begin
          top_d   = (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
          state_d = CLR_ROW;
          clr_d   = '0;
        end else begin
          row_d = '0;
        end
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    if (rx_valid && state_q != IDLE) ovf_d = 1'b1;
    if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT_CLR;
      row_q   <= '0;
      col_q   <= '0;
      top_q   <= '0;
      clr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      top_q   <= top_d;
      clr_q   <= clr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign rd_oob = (32'(rd_row) >= ROWS) || (32'(rd_col) >= COLS);
  assign raddr  = rd_oob ? '0 : cell_addr(phys_row(rd_row, top_q), rd_col);

  text_ram #(
    .DEPTH (CELLS),
    .ADDR_W(ADDR_W),
    .BLANK (BLANK)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr   (raddr),
    .rd_blank(rd_oob),
    .rd_data (rd_data)
  );

  assign rx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign overflow   = ovf_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_uart_text_terminal.sv
// Bench for uart_text_terminal: a scrolling and a wrapping instance checked
// each cycle against a logical-screen model, plus literal spot checks.
module tb_uart_text_terminal;

  localparam int         COLS  = 32;
  localparam int         ROWS  = 4;
  localparam int         COL_W = 5;
  localparam int         ROW_W = 2;
  localparam int         CELLS = ROWS * COLS;
  localparam logic [7:0] BL    = 8'h20;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       rx_data  [2];
  logic             rx_valid [2];
  logic             rx_ready [2];
  logic [ROW_W-1:0] rd_row   [2];
  logic [COL_W-1:0] rd_col   [2];
  logic [7:0]       rd_data  [2];
  logic [ROW_W-1:0] cur_row  [2];
  logic [COL_W-1:0] cur_col  [2];
  logic             busy     [2];
  logic             overflow [2];
  logic             clr_ovf  [2];

  always #5 clk = ~clk;

  uart_text_terminal #(.COLS(COLS), .ROWS(ROWS), .SCROLL_EN(1'b1), .BLANK(BL)) dut_scroll (
    .clk(clk), .reset(reset), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .rx_ready(rx_ready[0]), .rd_row(rd_row[0]), .rd_col(rd_col[0]), .rd_data(rd_data[0]),
    .cursor_row(cur_row[0]), .cursor_col(cur_col[0]), .busy(busy[0]),
    .overflow(overflow[0]), .clr_ovf(clr_ovf[0]));

  uart_text_terminal #(.COLS(COLS), .ROWS(ROWS), .SCROLL_EN(1'b0), .BLANK(BL)) dut_wrap (
    .clk(clk), .reset(reset), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .rx_ready(rx_ready[1]), .rd_row(rd_row[1]), .rd_col(rd_col[1]), .rd_data(rd_data[1]),
    .cursor_row(cur_row[1]), .cursor_col(cur_col[1]), .busy(busy[1]),
    .overflow(overflow[1]), .clr_ovf(clr_ovf[1]));

  // Model: screen held in logical row order; scrolling shifts rows up.
  logic [7:0] scr [2][ROWS][COLS];
  int         mr [2];
  int         mc [2];
  int         mbusy [2];
  bit         movf [2];
  bit         rd_chk [2];
  logic [7:0] exp_rd [2];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[i][r][c] = BL;
    mr[i] = 0; mc[i] = 0; mbusy[i] = CELLS; movf[i] = 1'b0;
    rd_chk[i] = 1'b1; exp_rd[i] = BL;
  endtask

  task automatic new_line(input int i);
    if (mr[i] == ROWS - 1) begin
      if (i == 0) begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int c = 0; c < COLS; c++) scr[i][r][c] = scr[i][r+1][c];
        for (int c = 0; c < COLS; c++) scr[i][ROWS-1][c] = BL;
        mbusy[i] = COLS;
      end else begin
        mr[i] = 0;
      end
    end else begin
      mr[i]++;
    end
  endtask

  task automatic model_step(input int i);
    logic [7:0] b;
    if (!reset) begin
      model_reset(i);
      return;
    end
    rd_chk[i] = (mbusy[i] == 0);
    exp_rd[i] = scr[i][rd_row[i]][rd_col[i]];
    if (mbusy[i] > 0) begin
      if (rx_valid[i]) movf[i] = 1'b1;
      mbusy[i]--;
    end else if (rx_valid[i]) begin
      b = rx_data[i];
      if (b >= 8'h20 && b <= 8'h7E) begin
        scr[i][mr[i]][mc[i]] = b;
        if (mc[i] < COLS - 1) mc[i]++;
        else begin mc[i] = 0; new_line(i); end
      end else if (b == 8'h0D) begin
        mc[i] = 0;
      end else if (b == 8'h0A) begin
        new_line(i);
      end else if (b == 8'h08) begin
        if (mc[i] > 0) begin
          mc[i]--; scr[i][mr[i]][mc[i]] = BL;
        end else if (mr[i] > 0) begin
          mr[i]--; mc[i] = COLS - 1; scr[i][mr[i]][mc[i]] = BL;
        end
      end else if (b == 8'h0C) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) scr[i][r][c] = BL;
        mr[i] = 0; mc[i] = 0; mbusy[i] = CELLS;
      end
    end
    if (clr_ovf[i]) movf[i] = 1'b0;
  endtask

  task automatic compare(input int i);
    string s;
    s = (i == 0) ? "scroll" : "wrap";
    chk({s, ".busy"}, 32'(busy[i]), 32'(mbusy[i] != 0));
    chk({s, ".rx_ready"}, 32'(rx_ready[i]), 32'(mbusy[i] == 0));
    chk({s, ".overflow"}, 32'(overflow[i]), 32'(movf[i]));
    if (mbusy[i] == 0) begin
      chk({s, ".cursor_row"}, 32'(cur_row[i]), mr[i]);
      chk({s, ".cursor_col"}, 32'(cur_col[i]), mc[i]);
    end
    if (rd_chk[i]) chk({s, ".rd_data"}, 32'(rd_data[i]), 32'(exp_rd[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) compare(i);
  endtask

  task automatic send(input int i, input logic [7:0] b);
    int n;
    n = 0;
    while (!rx_ready[i] && n < 1000) begin tick(); n++; end
    chk("ready_wait", 32'(rx_ready[i]), 1);
    rx_data[i]  = b;
    rx_valid[i] = 1'b1;
    tick();
    rx_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, output int n);
    n = 0;
    while (busy[i] && n < 1000) begin tick(); n++; end
  endtask

  task automatic expect_cell(input int i, input int r, input int c,
                             input logic [7:0] exp, input string name);
    rd_row[i] = ROW_W'(r);
    rd_col[i] = COL_W'(c);
    tick();
    chk(name, 32'(rd_data[i]), 32'(exp));
  endtask

  task automatic scan(input int i, input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < COLS; c++) begin
        rd_row[i] = ROW_W'(r);
        rd_col[i] = COL_W'(c);
        if (i == 0) begin rd_row[1] = ROW_W'(r); rd_col[1] = COL_W'(c); end
        tick();
      end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      rx_data[i] = 8'h00; rx_valid[i] = 1'b0; clr_ovf[i] = 1'b0;
      rd_row[i] = '0; rd_col[i] = '0;
      model_reset(i);
    end
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy[0]), 1);
    chk("rst_ready", 32'(rx_ready[0]), 0);
    chk("rst_cursor", 32'({cur_row[0], cur_col[0]}), 0);
    chk("rst_rd_data", 32'(rd_data[0]), 32'h20);
    reset = 1'b1;

    // T1: initial clear length and blank screen
    wait_idle(0, n);
    chk("init_len", n, CELLS);
    chk("init_wrap_idle", 32'(busy[1]), 0);
    scan(0, 0, ROWS - 1);

    // T2: "AB", CR, "C"
    send(0, "A"); send(0, "B"); send(0, 8'h0D); send(0, "C");
    expect_cell(0, 0, 0, "C", "t2_cell00");
    expect_cell(0, 0, 1, "B", "t2_cell01");
    chk("t2_cursor_col", 32'(cur_col[0]), 1);

    // T3: fill the screen and scroll once
    send(0, 8'h0C);
    wait_idle(0, n);
    chk("ff_len", n, CELLS);
    repeat (CELLS) send(0, "x");
    chk("t3_busy_after_fill", 32'(busy[0]), 1);
    wait_idle(0, n);
    chk("scroll_len", n, COLS);
    send(0, "x");
    expect_cell(0, 3, 0, "x", "t3_cell30");
    expect_cell(0, 3, 1, BL, "t3_cell31");
    expect_cell(0, 2, 31, "x", "t3_cell231");
    chk("t3_cursor_row", 32'(cur_row[0]), 3);
    chk("t3_cursor_col", 32'(cur_col[0]), 1);
    scan(0, 0, 2);

    // T4: wrapping instance
    repeat (CELLS) send(1, "a");
    chk("t4_no_busy", 32'(busy[1]), 0);
    send(1, "b");
    expect_cell(1, 0, 0, "b", "t4_cell00");
    expect_cell(1, 0, 1, "a", "t4_cell01");
    chk("t4_cursor_col", 32'(cur_col[1]), 1);
    repeat (3) send(1, 8'h0A);
    chk("t4_lf_row3", 32'(cur_row[1]), 3);
    send(1, 8'h0A);
    chk("t4_lf_wrap", 32'(cur_row[1]), 0);
    send(1, 8'h01);
    chk("t4_ignored", 32'({cur_row[1], cur_col[1]}), 1);

    // T5: backspace across a row boundary and at home
    send(0, 8'h0C);
    wait_idle(0, n);
    repeat (COLS) send(0, "k");
    chk("t5_cursor_row1", 32'(cur_row[0]), 1);
    send(0, 8'h08);
    chk("t5_bs_row", 32'(cur_row[0]), 0);
    chk("t5_bs_col", 32'(cur_col[0]), 31);
    expect_cell(0, 0, 31, BL, "t5_bs_cell");
    expect_cell(0, 0, 30, "k", "t5_keep_cell");
    send(0, 8'h0D);
    send(0, 8'h08);
    chk("t5_home_bs", 32'({cur_row[0], cur_col[0]}), 0);
    expect_cell(0, 0, 0, "k", "t5_home_cell");

    // T6: byte dropped while clearing, overflow set/clear
    send(0, 8'h0C);
    tick(); tick();
    rx_data[0] = "z"; rx_valid[0] = 1'b1;
    tick();
    rx_valid[0] = 1'b0;
    chk("t6_ovf_set", 32'(overflow[0]), 1);
    rx_valid[0] = 1'b1; clr_ovf[0] = 1'b1;
    tick();
    rx_valid[0] = 1'b0; clr_ovf[0] = 1'b0;
    chk("t6_clr_priority", 32'(overflow[0]), 0);
    rx_valid[0] = 1'b1;
    tick();
    rx_valid[0] = 1'b0;
    wait_idle(0, n);
    expect_cell(0, 0, 0, BL, "t6_z_absent");
    chk("t6_cursor", 32'({cur_row[0], cur_col[0]}), 0);
    chk("t6_ovf_sticky", 32'(overflow[0]), 1);
    clr_ovf[0] = 1'b1;
    tick();
    clr_ovf[0] = 1'b0;
    chk("t6_ovf_clr", 32'(overflow[0]), 0);

    // Reset in the middle of a clear
    send(0, "m");
    send(0, 8'h0C);
    rx_valid[0] = 1'b1;
    tick();
    rx_valid[0] = 1'b0;
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(busy[0]), 1);
    chk("mid_rst_ovf", 32'(overflow[0]), 0);
    chk("mid_rst_wrap_cursor", 32'({cur_row[1], cur_col[1]}), 0);
    reset = 1'b1;
    wait_idle(0, n);
    chk("mid_rst_init_len", n, CELLS);
    scan(0, 0, ROWS - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
